// File: rtl/sweep_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sweep_engine
//  Purpose  : Triangle / sawtooth / one-shot linear frequency sweep around a
//             base value, clamped to a band, with shadowed reconfiguration.
//  Revision : 1.0 - initial release
// ============================================================================
module sweep_engine #(
    parameter int FREQ_W   = 20,
    parameter int RANGE_W  = 17,
    parameter int STEP_W   = 13,
    parameter int TICK_DIV = 100,
    parameter int FREQ_MIN = 1000,
    parameter int FREQ_MAX = 999000,
    parameter int RST_FREQ = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [FREQ_W-1:0]  cfg_base,
    input  logic [RANGE_W-1:0] cfg_range,
    input  logic [STEP_W-1:0]  cfg_step,
    input  logic [2:0]         cfg_mode,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    output logic [FREQ_W-1:0]  freq_out,
    output logic               freq_valid,
    output logic               sweep_dir,
    output logic               sweep_active,
    output logic               wrap,
    output logic               sweep_done
);

    localparam int c_OFF_W = RANGE_W + 1;
    localparam int c_ARI_W = RANGE_W + 2;
    localparam int c_SUM_W = FREQ_W + 2;
    localparam int c_PRE_W = $clog2(TICK_DIV);

    localparam logic [c_PRE_W-1:0]        c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic signed [c_SUM_W-1:0] c_FMIN     = c_SUM_W'(FREQ_MIN);
    localparam logic signed [c_SUM_W-1:0] c_FMAX     = c_SUM_W'(FREQ_MAX);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [2:0] c_MODE_TRI    = 3'd1;
    localparam logic [2:0] c_MODE_SAW_UP = 3'd2;
    localparam logic [2:0] c_MODE_SAW_DN = 3'd3;
    localparam logic [2:0] c_MODE_OS_UP  = 3'd4;
    localparam logic [2:0] c_MODE_OS_DN  = 3'd5;

    logic [1:0]                r_state, w_state_nxt;
    logic signed [c_OFF_W-1:0] r_offset, w_off_nxt;
    logic                      r_dir, w_dir_nxt;
    logic [c_PRE_W-1:0]        r_presc, w_pre_nxt;
    logic [FREQ_W-1:0]         r_base, r_sh_base;
    logic [RANGE_W-1:0]        r_range, r_sh_range;
    logic [STEP_W-1:0]         r_step, r_sh_step;
    logic [2:0]                r_mode, r_sh_mode;
    logic                      r_sh_valid;
    logic [FREQ_W-1:0]         r_freq_out;
    logic                      r_freq_valid, r_src_chg, r_wrap, r_done;
    logic                      w_chg_nxt, w_wrap_nxt, w_done_nxt;

    function automatic logic [c_OFF_W-1:0] f_start_off(input logic [2:0] mode,
                                                       input logic [RANGE_W-1:0] rng);
        logic [c_OFF_W-1:0] v_pos;
        v_pos = {1'b0, rng};
        case (mode)
            c_MODE_SAW_UP, c_MODE_OS_UP: f_start_off = -v_pos;
            c_MODE_SAW_DN, c_MODE_OS_DN: f_start_off = v_pos;
            default:                     f_start_off = '0;
        endcase
    endfunction

    function automatic logic f_start_dir(input logic [2:0] mode);
        f_start_dir = (mode == c_MODE_SAW_DN) || (mode == c_MODE_OS_DN);
    endfunction

    logic w_running, w_accept, w_advance, w_tick, w_apply, w_to_shadow;
    logic [FREQ_W-1:0]  w_new_base;
    logic [RANGE_W-1:0] w_new_range, w_act_range;
    logic [STEP_W-1:0]  w_new_step;
    logic [2:0]         w_new_mode, w_act_mode;

    assign w_running = (r_state == c_RUN) || (r_state == c_HOLD);
    assign w_accept  = cfg_valid && !r_sh_valid;
    assign w_advance = w_running && !hold && !start && !stop;
    assign w_tick    = w_advance && (r_presc == c_PRE_LAST);

    // ready is low only while a shadow is pending, so the two sources never collide
    assign w_new_base  = w_accept ? cfg_base  : r_sh_base;
    assign w_new_range = w_accept ? cfg_range : r_sh_range;
    assign w_new_step  = w_accept ? cfg_step  : r_sh_step;
    assign w_new_mode  = w_accept ? cfg_mode  : r_sh_mode;

    // Per-tick offset arithmetic, one bit wider than the offset
    logic signed [c_ARI_W-1:0] w_off_ext, w_rng, w_rng_neg, w_stp, w_plus, w_minus;
    logic signed [c_ARI_W-1:0] w_tick_off;
    logic                      w_tick_dir, w_tick_wrap, w_tick_end, w_tick_upd;

    assign w_off_ext = {r_offset[c_OFF_W-1], r_offset};
    assign w_rng     = $signed({2'b00, r_range});
    assign w_rng_neg = -w_rng;
    assign w_stp     = $signed({{(c_ARI_W - STEP_W){1'b0}}, r_step});
    assign w_plus    = w_off_ext + w_stp;
    assign w_minus   = w_off_ext - w_stp;

    always_comb begin
        w_tick_off  = w_off_ext;
        w_tick_dir  = r_dir;
        w_tick_wrap = 1'b0;
        w_tick_end  = 1'b0;
        w_tick_upd  = 1'b1;
        case (r_mode)
            c_MODE_TRI: begin
                if (!r_dir) begin
                    if (w_plus >= w_rng) begin
                        w_tick_off = w_rng;
                        w_tick_dir = 1'b1;
                    end else begin
                        w_tick_off = w_plus;
                    end
                end else if (w_minus <= w_rng_neg) begin
                    w_tick_off  = w_rng_neg;
                    w_tick_dir  = 1'b0;
                    w_tick_wrap = 1'b1;
                end else begin
                    w_tick_off = w_minus;
                end
            end
            c_MODE_SAW_UP: begin
                if (w_plus > w_rng) begin
                    w_tick_off  = w_rng_neg;
                    w_tick_wrap = 1'b1;
                end else begin
                    w_tick_off = w_plus;
                end
            end
            c_MODE_SAW_DN: begin
                if (w_minus < w_rng_neg) begin
                    w_tick_off  = w_rng;
                    w_tick_wrap = 1'b1;
                end else begin
                    w_tick_off = w_minus;
                end
            end
            c_MODE_OS_UP: begin
                if (w_plus >= w_rng) begin
                    w_tick_off = w_rng;
                    w_tick_end = 1'b1;
                end else begin
                    w_tick_off = w_plus;
                end
            end
            c_MODE_OS_DN: begin
                if (w_minus <= w_rng_neg) begin
                    w_tick_off = w_rng_neg;
                    w_tick_end = 1'b1;
                end else begin
                    w_tick_off = w_minus;
                end
            end
            default: w_tick_upd = 1'b0;
        endcase
    end

    // Config lands directly when idle/done; otherwise at a wrap, one-shot end, start or stop
    assign w_apply = (!w_running && w_accept)
                   || (w_running && (start || stop) && (w_accept || r_sh_valid))
                   || (r_sh_valid && w_tick && w_tick_upd && (w_tick_wrap || w_tick_end));
    assign w_to_shadow = w_running && w_accept && !start && !stop;
    assign w_act_mode  = w_apply ? w_new_mode  : r_mode;
    assign w_act_range = w_apply ? w_new_range : r_range;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (start) w_state_nxt = c_RUN;
            c_RUN, c_HOLD: begin
                if (hold)                                  w_state_nxt = c_HOLD;
                else if (w_tick && w_tick_upd && w_tick_end) w_state_nxt = c_DONE;
                else                                       w_state_nxt = c_RUN;
            end
            default: w_state_nxt = c_IDLE;
        endcase
        if (stop)       w_state_nxt = c_IDLE;
        else if (start) w_state_nxt = c_RUN;
    end

    always_comb begin
        w_off_nxt  = r_offset;
        w_dir_nxt  = r_dir;
        w_pre_nxt  = r_presc;
        w_wrap_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_chg_nxt  = w_apply;
        if (stop) begin
            w_off_nxt = '0;
            w_dir_nxt = 1'b0;
            w_pre_nxt = '0;
            w_chg_nxt = 1'b1;
        end else if (start) begin
            w_off_nxt = f_start_off(w_act_mode, w_act_range);
            w_dir_nxt = f_start_dir(w_act_mode);
            w_pre_nxt = '0;
            w_chg_nxt = 1'b1;
        end else if (w_advance) begin
            w_pre_nxt = w_tick ? '0 : r_presc + c_PRE_W'(1);
            if (w_tick && w_tick_upd) begin
                w_wrap_nxt = w_tick_wrap;
                w_done_nxt = w_tick_end;
                w_chg_nxt  = 1'b1;
                if (w_apply) begin
                    w_off_nxt = f_start_off(w_act_mode, w_act_range);
                    w_dir_nxt = f_start_dir(w_act_mode);
                end else begin
                    w_off_nxt = w_tick_off[c_OFF_W-1:0];
                    w_dir_nxt = w_tick_dir;
                end
            end
        end
    end

    logic signed [c_SUM_W-1:0] w_sum;
    logic [FREQ_W-1:0]         w_clamped;

    assign w_sum = $signed({2'b00, r_base})
                 + $signed({{(c_SUM_W - c_OFF_W){r_offset[c_OFF_W-1]}}, r_offset});

    always_comb begin
        w_clamped = w_sum[FREQ_W-1:0];
        if (w_sum < c_FMIN)      w_clamped = FREQ_W'(FREQ_MIN);
        else if (w_sum > c_FMAX) w_clamped = FREQ_W'(FREQ_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_offset     <= '0;
            r_dir        <= 1'b0;
            r_presc      <= '0;
            r_base       <= FREQ_W'(RST_FREQ);
            r_range      <= '0;
            r_step       <= '0;
            r_mode       <= '0;
            r_sh_base    <= '0;
            r_sh_range   <= '0;
            r_sh_step    <= '0;
            r_sh_mode    <= '0;
            r_sh_valid   <= 1'b0;
            r_freq_out   <= FREQ_W'(RST_FREQ);
            r_freq_valid <= 1'b0;
            r_src_chg    <= 1'b0;
            r_wrap       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_offset     <= w_off_nxt;
            r_dir        <= w_dir_nxt;
            r_presc      <= w_pre_nxt;
            r_src_chg    <= w_chg_nxt;
            r_wrap       <= w_wrap_nxt;
            r_done       <= w_done_nxt;
            r_freq_out   <= w_clamped;
            r_freq_valid <= r_src_chg;
            if (w_apply) begin
                r_base     <= w_new_base;
                r_range    <= w_new_range;
                r_step     <= w_new_step;
                r_mode     <= w_new_mode;
                r_sh_valid <= 1'b0;
            end else if (w_to_shadow) begin
                r_sh_base  <= cfg_base;
                r_sh_range <= cfg_range;
                r_sh_step  <= cfg_step;
                r_sh_mode  <= cfg_mode;
                r_sh_valid <= 1'b1;
            end
        end
    end

    assign cfg_ready    = !r_sh_valid;
    assign freq_out     = r_freq_out;
    assign freq_valid   = r_freq_valid;
    assign sweep_dir    = r_dir;
    assign sweep_active = w_running;
    assign wrap         = r_wrap;
    assign sweep_done   = r_done;

endmodule
`default_nettype wire
